filter_rx_multirule: RTL

- Parametrised successor of the box_250mhz RX filter stage; sits between the adapter RX stream and the QDMA C2H stream.
- Evaluates NUM_RULES prioritised rules on the first beat of each Ethernet/IPv4/IPv6 packet:
  - IPv4 source address is masked;
  - IPv6 source address is exact-match or wildcard;
  - L4 port is source or destination, selectable per rule.
- Forwards or drops whole packets, and keeps per-rule hit counters with saturation and a synchronous clear.

---
 rtl/filter_rx_multirule.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/filter_rx_multirule.sv
// Multi-rule RX packet filter: IPv4/IPv6 source and L4 port rules,
// decided on the first beat, with two output register stages.
module filter_rx_multirule #(
  parameter int DATA_W       = 512,
  parameter int USER_W       = 48,
  parameter int NUM_RULES    = 4,
  parameter int CNT_W        = 32,
  parameter bit DEFAULT_PASS = 1'b0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_axis_tvalid,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic [DATA_W/8-1:0]        s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic [USER_W-1:0]          s_axis_tuser,
  output logic                       s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [USER_W-1:0]          m_axis_tuser,
  input  logic                       m_axis_tready,
  input  logic [NUM_RULES-1:0]       rule_en,
  input  logic [NUM_RULES*32-1:0]    rule_ipv4_addr,
  input  logic [NUM_RULES*32-1:0]    rule_ipv4_mask,
  input  logic [NUM_RULES*128-1:0]   rule_ipv6_addr,
  input  logic [NUM_RULES*16-1:0]    rule_port,
  input  logic [NUM_RULES-1:0]       rule_port_dst,
  input  logic [NUM_RULES-1:0]       rule_pass,
  input  logic                       stat_clear,
  output logic [NUM_RULES*CNT_W-1:0] stat_rule_hits,
  output logic [CNT_W-1:0]           stat_total_pkts,
  output logic [CNT_W-1:0]           stat_fwd_pkts,
  output logic [CNT_W-1:0]           stat_drop_pkts,
  output logic [CNT_W-1:0]           stat_nomatch_pkts
);

  localparam int T = DATA_W - 1;

  logic in_pkt_q, pass_q;
  logic p1_valid_q, p1_pass_q, p1_last_q;
  logic [DATA_W-1:0] p1_data_q;
  logic [DATA_W/8-1:0] p1_keep_q;
  logic [USER_W-1:0] p1_user_q;
  logic p2_valid_q, p2_last_q;
  logic [DATA_W-1:0] p2_data_q;
  logic [DATA_W/8-1:0] p2_keep_q;
  logic [USER_W-1:0] p2_user_q;

  logic p1_ready, p2_ready, accept, sop, beat_pass;
  logic [NUM_RULES-1:0] hit, win_oh;
  logic any_hit, decision;

  assign p2_ready      = !p2_valid_q | m_axis_tready;
  assign p1_ready      = !p1_valid_q | p2_ready;
  assign s_axis_tready = p1_ready;
  assign accept        = s_axis_tvalid & p1_ready;
  assign sop           = accept & !in_pkt_q;

  // Header extraction and per-rule match with lowest-index priority
  always_comb begin
    logic [15:0]  eth, sp, dp, rp, selp;
    logic [31:0]  src4, a4, m4;
    logic [127:0] src6, a6;
    logic is_v4, is_v6, addr_ok, found;
    eth   = s_axis_tdata[T-96 -: 16];
    is_v4 = (eth == 16'h0800);
    is_v6 = (eth == 16'h86DD);
    src4  = s_axis_tdata[T-208 -: 32];
    src6  = s_axis_tdata[T-176 -: 128];
    sp    = is_v4 ? s_axis_tdata[T-272 -: 16] : s_axis_tdata[T-432 -: 16];
    dp    = is_v4 ? s_axis_tdata[T-288 -: 16] : s_axis_tdata[T-448 -: 16];
    hit    = '0;
    win_oh = '0;
    found  = 1'b0;
    for (int r = 0; r < NUM_RULES; r++) begin
      a4   = rule_ipv4_addr[32*r +: 32];
      m4   = rule_ipv4_mask[32*r +: 32];
      a6   = rule_ipv6_addr[128*r +: 128];
      rp   = rule_port[16*r +: 16];
      selp = rule_port_dst[r] ? dp : sp;
      addr_ok = (is_v4 && (((src4 ^ a4) & m4) == 32'h0)) ||
                (is_v6 && ((a6 == 128'h0) || (src6 == a6)));
      hit[r]    = rule_en[r] && addr_ok && ((rp == 16'h0) || (rp == selp));
      win_oh[r] = hit[r] && !found;
      found     = found | hit[r];
    end
    any_hit  = found;
    decision = any_hit ? |(win_oh & rule_pass) : DEFAULT_PASS;
  end

  assign beat_pass = sop ? decision : pass_q;

  // Packet tracking and pipeline valid flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      in_pkt_q   <= 1'b0;
      pass_q     <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_pass_q  <= 1'b0;
      p2_valid_q <= 1'b0;
    end else begin
      if (accept) in_pkt_q <= !s_axis_tlast;
      if (sop) pass_q <= decision;
      if (p1_ready) begin
        p1_valid_q <= accept;
        p1_pass_q  <= beat_pass;
      end
      if (p2_ready) p2_valid_q <= p1_valid_q & p1_pass_q;
    end
  end

  // Payload registers; dropped beats never load P2
  always_ff @(posedge aclk) begin
    if (p1_ready && accept) begin
      p1_data_q <= s_axis_tdata;
      p1_keep_q <= s_axis_tkeep;
      p1_last_q <= s_axis_tlast;
      p1_user_q <= s_axis_tuser;
    end
    if (p2_ready && p1_valid_q && p1_pass_q) begin
      p2_data_q <= p1_data_q;
      p2_keep_q <= p1_keep_q;
      p2_last_q <= p1_last_q;
      p2_user_q <= p1_user_q;
    end
  end

  assign m_axis_tvalid = p2_valid_q;
  assign m_axis_tdata  = p2_data_q;
  assign m_axis_tkeep  = p2_keep_q;
  assign m_axis_tlast  = p2_last_q;
  assign m_axis_tuser  = p2_user_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] hits_q [NUM_RULES];
  logic [CNT_W-1:0] total_q, fwd_q, drop_q, nomatch_q;

  // Saturating statistics; clear wins over a coincident SOP
  always_ff @(posedge aclk) begin
    if (areset || stat_clear) begin
      total_q   <= '0;
      fwd_q     <= '0;
      drop_q    <= '0;
      nomatch_q <= '0;
      for (int r = 0; r < NUM_RULES; r++) hits_q[r] <= '0;
    end else if (sop) begin
      total_q <= sat_inc(total_q);
      if (decision) fwd_q <= sat_inc(fwd_q);
      else drop_q <= sat_inc(drop_q);
      if (!any_hit) nomatch_q <= sat_inc(nomatch_q);
      for (int r = 0; r < NUM_RULES; r++)
        if (win_oh[r]) hits_q[r] <= sat_inc(hits_q[r]);
    end
  end

  // Flatten per-rule counters onto the output bus
  always_comb begin
    stat_rule_hits = '0;
    for (int r = 0; r < NUM_RULES; r++)
      stat_rule_hits[r*CNT_W +: CNT_W] = hits_q[r];
  end

  assign stat_total_pkts   = total_q;
  assign stat_fwd_pkts     = fwd_q;
  assign stat_drop_pkts    = drop_q;
  assign stat_nomatch_pkts = nomatch_q;

endmodule
